// File: rtl/bitwise_logic_unit.sv
// Multi-cycle AND/OR/XOR/NOR unit, SLICE bits per clock, start/busy/done handshake, N-clock latency.
// Optional BLU_ABORT_EN adds an abort input that cancels a running operation.
module bitwise_logic_unit #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef BLU_ABORT_EN
   input  logic             abort,
`endif
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int N  = WIDTH / SLICE;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, part, full;
   logic [IW-1:0]    idx;
   logic [SLICE-1:0] a_s, b_s, y_s;
   logic             accept, last, kill;
   int               base;

   assign accept = start && (state != RUN);
   assign last   = (idx == LAST);
`ifdef BLU_ABORT_EN
   assign kill   = abort && (state == RUN);
`else
   assign kill   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN: begin
            if (kill)      state_nxt = IDLE;
            else if (last) state_nxt = DONE;
         end
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Slice of the latched operands selected by idx, merged into the partial word.
   always_comb begin
      base = int'(idx) * SLICE;
      a_s  = a_q[base +: SLICE];
      b_s  = b_q[base +: SLICE];
      case (op_q)
         2'b00:   y_s = a_s & b_s;
         2'b01:   y_s = a_s | b_s;
         2'b10:   y_s = a_s ^ b_s;
         default: y_s = ~(a_s | b_s);
      endcase
      full = part;
      full[base +: SLICE] = y_s;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         idx    <= '0;
         part   <= '0;
         result <= '0;
         zero   <= 1'b1;
      end else if (accept) begin
         op_q <= op;
         a_q  <= a;
         b_q  <= b;
         idx  <= '0;
         part <= '0;
      end else if (state == RUN && !kill) begin
         part <= full;
         // idx saturates at the last slice; the next accept clears it.
         if (!last) begin
            idx <= idx + 1'b1;
         end else begin
            result <= full;
            zero   <= (full == '0);
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Directed bench for bitwise_logic_unit: an 8-bit-slice instance and a single-slice instance.
module tb_bitwise_logic_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = '0, b = '0;
   logic        busy, done, zero, busy2, done2, zero2;
   logic [31:0] result, result2;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bitwise_logic_unit #(.WIDTH(32), .SLICE(8)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef BLU_ABORT_EN
      .abort(abort),
`endif
      .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .zero(zero)
   );

   bitwise_logic_unit #(.WIDTH(32), .SLICE(32)) dut2 (
      .clk(clk), .rst_n(rst_n),
`ifdef BLU_ABORT_EN
      .abort(abort),
`endif
      .start(start), .op(op), .a(a), .b(b),
      .busy(busy2), .done(done2), .result(result2), .zero(zero2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge with start already driven; returns at the negedge after done.
   task automatic wait_done(input string tag, input logic inject,
                            input logic [31:0] exp_res, input logic exp_zero);
      int k;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!done && k < 20) begin
         check({tag, "_busy"}, busy, 1);
         if (inject && k == 1) begin
            start = 1'b1; op = 2'b00; a = '0; b = '0;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      check({tag, "_latency"}, k, 4);
      check({tag, "_busy_at_done"}, busy, 0);
      check({tag, "_result"}, result, exp_res);
      check({tag, "_zero"}, zero, exp_zero);
   endtask

   initial begin
      #3 rst_n = 1'b0;
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_result", result, 32'h0);
      check("rst_zero", zero, 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // AND
      start = 1'b1; op = 2'b00; a = 32'hF0F0F0F0; b = 32'hFF00FF00;
      wait_done("and", 1'b0, 32'hF000F000, 1'b0);
      @(negedge clk);
      check("and_done_pulse", done, 0);

      // XOR equal operands, then NOR started during DONE
      start = 1'b1; op = 2'b10; a = 32'h12345678; b = 32'h12345678;
      wait_done("xor", 1'b0, 32'h00000000, 1'b1);
      start = 1'b1; op = 2'b11; a = '0; b = '0;
      wait_done("nor", 1'b0, 32'hFFFFFFFF, 1'b0);
      @(negedge clk);
      check("nor_done_pulse", done, 0);

      // OR with a stray start during RUN
      start = 1'b1; op = 2'b01; a = 32'h0000FFFF; b = 32'h00FF0000;
      wait_done("or_ignore", 1'b1, 32'h00FFFFFF, 1'b0);
      @(negedge clk);

      // Single-slice instance
      start = 1'b1; op = 2'b01; a = 32'h80000000; b = 32'h00000001;
      @(negedge clk);
      start = 1'b0;
      check("s32_busy", busy2, 1);
      check("s32_done_early", done2, 0);
      @(negedge clk);
      check("s32_done", done2, 1);
      check("s32_busy_at_done", busy2, 0);
      check("s32_result", result2, 32'h80000001);
      check("s32_zero", zero2, 0);
      begin
         int k = 0;
         while (!done && k < 20) begin
            @(negedge clk);
            k++;
         end
         check("s8_or_result", result, 32'h80000001);
      end
      @(negedge clk);

      // Cancel mid-operation at the cycle after E2
      start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
`ifdef BLU_ABORT_EN
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_result", result, 32'h80000001);
      check("abort_zero", zero, 0);
`else
      rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_result", result, 32'h0);
      check("midrst_zero", zero, 1);
      @(negedge clk);
      rst_n = 1'b1;
`endif
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("no_done_after_cancel", done, 0);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
